// File: rtl/pwm_sequencer.sv
// Multi-channel PWM power sequencer: staggered channel enables, ramped duty
// up/down, settle detection and sticky per-channel interrupt flags.
module pwm_sequencer #(
  parameter int unsigned NCH = 5,
  parameter int unsigned DW  = 8
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [15:0]       stagger_cycles,
  input  logic [7:0]        ramp_div,
  input  logic [NCH*DW-1:0] target_duty,
  input  logic [NCH-1:0]    irq_in,
  input  logic [NCH-1:0]    irq_ack,
  output logic [NCH-1:0]    enable_out,
  output logic [NCH*DW-1:0] duty_out,
  output logic              busy,
  output logic              settled,
  output logic              done,
  output logic [NCH-1:0]    irq_pending,
  output logic              irq
);

  localparam int unsigned SW = $clog2(NCH + 1);

  typedef enum logic [1:0] {IDLE, STAGGER, RUN, DOWN} state_t;

  state_t            state, state_nx;
  logic [SW-1:0]     slot, slot_nx;
  logic              slot_pend, slot_pend_nx;
  logic [15:0]       rem, rem_nx;
  logic [7:0]        pcnt, pcnt_nx;
  logic [NCH-1:0]    mask_l, mask_l_nx;
  logic [NCH-1:0]    enable_nx, pend_nx;
  logic [NCH*DW-1:0] duty_nx;
  logic              busy_nx, settled_nx, done_nx, irq_nx;
  logic              tick;

  // Next-state, slot sequencing, duty ramp and flag computation
  always_comb begin
    logic [DW-1:0] cur;
    logic [DW-1:0] tgt;
    state_nx     = state;
    slot_nx      = slot;
    slot_pend_nx = slot_pend;
    rem_nx       = rem;
    pcnt_nx      = pcnt;
    mask_l_nx    = mask_l;
    enable_nx    = enable_out;
    duty_nx      = duty_out;
    done_nx      = 1'b0;
    cur          = '0;
    tgt          = '0;

    // Prescaler runs in every active state; >= guards a shrinking ramp_div
    tick = (state != IDLE) && (pcnt >= ramp_div);
    if (state != IDLE) begin
      pcnt_nx = tick ? 8'd0 : pcnt + 8'd1;
    end

    // Enabled channels step one count toward the effective target per tick
    for (int k = 0; k < NCH; k++) begin
      if (enable_out[k] && tick) begin
        cur = duty_out[k*DW +: DW];
        tgt = (state == DOWN) ? '0 : target_duty[k*DW +: DW];
        if (cur < tgt) begin
          duty_nx[k*DW +: DW] = cur + DW'(1);
        end else if (cur > tgt) begin
          duty_nx[k*DW +: DW] = cur - DW'(1);
        end
      end
    end

    case (state)
      IDLE: begin
        if (start && !stop && (chan_mask != '0)) begin
          state_nx     = STAGGER;
          slot_nx      = '0;
          slot_pend_nx = 1'b1;
          rem_nx       = '0;
          pcnt_nx      = '0;
          mask_l_nx    = chan_mask;
        end
      end
      STAGGER: begin
        if (stop) begin
          state_nx = DOWN;
        end else if (slot_pend) begin
          // A pending "slot NCH" means every real slot has run its course
          if (slot == SW'(NCH)) begin
            state_nx = RUN;
          end else begin
            for (int k = 0; k < NCH; k++) begin
              if (slot == SW'(k)) enable_nx[k] = mask_l[k];
            end
            if (stagger_cycles == 16'd0) begin
              slot_nx = slot + SW'(1);
            end else begin
              rem_nx       = stagger_cycles;
              slot_pend_nx = 1'b0;
            end
          end
        end else if (rem == 16'd1) begin
          slot_nx      = slot + SW'(1);
          slot_pend_nx = 1'b1;
        end else begin
          rem_nx = rem - 16'd1;
        end
      end
      RUN: begin
        if (stop) state_nx = DOWN;
      end
      DOWN: begin
        if (duty_out == '0) begin
          state_nx  = IDLE;
          enable_nx = '0;
          done_nx   = 1'b1;
          pcnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Set beats ack in the same cycle
    pend_nx = (irq_pending & ~irq_ack) | (irq_in & enable_out);
    irq_nx  = |pend_nx;
    busy_nx = (state_nx != IDLE);

    settled_nx = (state_nx == RUN);
    for (int k = 0; k < NCH; k++) begin
      if (enable_nx[k] && (duty_nx[k*DW +: DW] != target_duty[k*DW +: DW])) begin
        settled_nx = 1'b0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= '0;
      slot_pend   <= 1'b0;
      rem         <= '0;
      pcnt        <= '0;
      mask_l      <= '0;
      enable_out  <= '0;
      duty_out    <= '0;
      busy        <= 1'b0;
      settled     <= 1'b0;
      done        <= 1'b0;
      irq_pending <= '0;
      irq         <= 1'b0;
    end else begin
      state       <= state_nx;
      slot        <= slot_nx;
      slot_pend   <= slot_pend_nx;
      rem         <= rem_nx;
      pcnt        <= pcnt_nx;
      mask_l      <= mask_l_nx;
      enable_out  <= enable_nx;
      duty_out    <= duty_nx;
      busy        <= busy_nx;
      settled     <= settled_nx;
      done        <= done_nx;
      irq_pending <= pend_nx;
      irq         <= irq_nx;
    end
  end

endmodule
